// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the adder-result UART transmitter.
// The FSM state encoding and the parity selector values live here.
package sum_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of serial bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_w, input int parity);
        return data_w + 2 + ((parity != PAR_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/sum_uart_tx_baud.sv
// Bit-period timer: counts enabled cycles 0..CLK_DIV-1 and flags the last one.
// It is the only source of bit timing for the transmitter.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
            $error("uart_baud_tick: CLK_DIV must be in 2..65535");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/sum_uart_tx.sv
// UART transmitter for the adder sum: accepts a word on valid/ready and
// shifts it out as start, LSB-first data, optional parity and stop bits.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DATA_W  = 8,
    parameter int PARITY  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    generate
        if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
            $error("sum_uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
        end
    endgenerate

    state_t            r_state;
    logic [DATA_W-1:0] r_sr;
    logic              r_par;
    logic [IDX_W-1:0]  r_idx;
    logic              r_tx;
    logic              r_busy;

    logic              w_tick;
    logic              w_accept;
    logic              w_last_bit;
    logic              w_state_change;
    logic              w_baud_en;
    logic [DATA_W-1:0] w_sr_shift;

    assign ready_out  = (r_state == IDLE) && ena;
    assign w_accept   = valid_in && ready_out;
    assign w_last_bit = (r_idx == LAST_IDX);
    assign w_baud_en  = ena && (r_state != IDLE);
    assign w_sr_shift = r_sr >> 1;

    // Every transition restarts the bit timer; within DATA the timer wraps on its own.
    assign w_state_change = w_accept ||
                            (w_tick && ((r_state != DATA) || w_last_bit));

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_baud_en),
        .clr   (w_state_change),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_par   <= 1'b0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= START;
                        r_sr    <= data_in;
                        r_par   <= (PARITY == PAR_ODD) ? ~^data_in : ^data_in;
                        r_idx   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_idx   <= '0;
                        r_tx    <= r_sr[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (w_last_bit) begin
                            r_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                r_state <= PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_sr  <= w_sr_shift;
                            r_idx <= r_idx + 1'b1;
                            r_tx  <= w_sr_shift[0];
                        end
                    end
                end
                PAR: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: three instances (no/even/odd parity) at CLK_DIV=4,
// with a per-instance line monitor that decodes frames against a queue of expected frames.
module tb_sum_uart_tx;
    import sum_uart_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 8;
    localparam int N_DUT   = 3;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          rawlen;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       ena     = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ena_q   = 1'b0;
    logic       valid     [N_DUT];
    logic       ready     [N_DUT];
    logic       tx        [N_DUT];
    logic       busy      [N_DUT];
    logic       in_frame  [N_DUT];
    int         gap_start [N_DUT];
    exp_t       sb_q      [N_DUT][$];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ena_q <= ena;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line levels of a whole frame, index 0 = start bit.
    function automatic logic [15:0] expected_frame(input logic [7:0] data, input int par);
        logic [15:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[1+k] = data[k];
        if (par == PAR_NONE) begin
            f[9] = 1'b1;
        end else begin
            f[9]  = (par == PAR_EVEN) ? ^data : ~^data;
            f[10] = 1'b1;
        end
        return f;
    endfunction

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        sum_uart_tx #(
            .CLK_DIV (CLK_DIV),
            .DATA_W  (DATA_W),
            .PARITY  (gi)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena),
            .data_in   (data_in),
            .valid_in  (valid[gi]),
            .ready_out (ready[gi]),
            .tx        (tx[gi]),
            .busy      (busy[gi])
        );

        int          en_cnt;
        int          raw_cnt;
        int          last_end;
        logic [15:0] got;
        logic        post;

        initial begin
            en_cnt        = 0;
            raw_cnt       = 0;
            last_end      = 0;
            got           = '0;
            post          = 1'b0;
            in_frame[gi]  = 1'b0;
            gap_start[gi] = 0;
        end

        always @(negedge clk) begin
            logic adv;
            exp_t e;
            adv = 1'b0;
            if (!rst_n) begin
                in_frame[gi] = 1'b0;
                post         = 1'b0;
            end else if (!in_frame[gi]) begin
                if (post) begin
                    post = 1'b0;
                    chk($sformatf("dut%0d_after_stop_busy", gi), busy[gi], 0);
                    chk($sformatf("dut%0d_after_stop_ready", gi), ready[gi], ena);
                    chk($sformatf("dut%0d_after_stop_tx", gi), tx[gi], 1);
                end
                if (tx[gi] === 1'b0) begin
                    in_frame[gi]  = 1'b1;
                    en_cnt        = 1;
                    raw_cnt       = 1;
                    got           = '0;
                    gap_start[gi] = cyc - last_end;
                    adv           = 1'b1;
                end
            end else begin
                raw_cnt++;
                if (ena_q) begin
                    en_cnt++;
                    adv = 1'b1;
                end
            end
            if (in_frame[gi]) begin
                chk($sformatf("dut%0d_busy_in_frame", gi), busy[gi], 1);
                chk($sformatf("dut%0d_ready_in_frame", gi), ready[gi], 0);
            end
            if (adv) begin
                if (en_cnt % CLK_DIV == CLK_DIV / 2) got[en_cnt / CLK_DIV] = tx[gi];
                if (en_cnt == frame_bits(DATA_W, gi) * CLK_DIV) begin
                    in_frame[gi] = 1'b0;
                    post         = 1'b1;
                    last_end     = cyc;
                    if (sb_q[gi].size() == 0) begin
                        chk($sformatf("dut%0d_unexpected_frame", gi), got, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q[gi].pop_front();
                        chk($sformatf("dut%0d_frame_bits", gi), got, e.bits);
                        chk($sformatf("dut%0d_frame_len", gi), raw_cnt, e.rawlen);
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [7:0] data, input int extra, input bit keep);
        exp_t e;
        int   waited;
        data_in  = data;
        valid[d] = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (ready[d] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("dut%0d_accept_wait", d), waited < 200, 1);
        if (waited < 200) begin
            e.bits   = expected_frame(data, d);
            e.nbits  = frame_bits(DATA_W, d);
            e.rawlen = e.nbits * CLK_DIV + extra;
            sb_q[d].push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) valid[d] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_wait", t < 2000, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N_DUT; i++) valid[i] = 1'b0;

        // Reset held for three cycles, then released with ena=1
        #2 rst_n = 1'b0;
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_tx", tx[0], 1);
        chk("reset_hold_busy", busy[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("dut%0d_reset_tx", i), tx[i], 1);
            chk($sformatf("dut%0d_reset_busy", i), busy[i], 0);
            chk($sformatf("dut%0d_reset_ready", i), ready[i], 1);
        end
        @(posedge clk);
        #1;

        // Plain frame, no parity
        send(0, 8'hA5, 0, 1'b0);
        wait_drain();

        // Parity frames
        send(1, 8'hA5, 0, 1'b0);
        wait_drain();
        send(2, 8'h07, 0, 1'b0);
        wait_drain();
        send(1, 8'h07, 0, 1'b0);
        wait_drain();

        // Back-to-back with valid held: one idle cycle between frames
        send(0, 8'h01, 0, 1'b1);
        send(0, 8'hFF, 0, 1'b0);
        wait_drain();
        chk("b2b_gap", gap_start[0], 2);

        // Freeze for 10 cycles in data bit 3 (0x5A bit3 = 1)
        send(0, 8'h5A, 10, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("freeze_tx", tx[0], 1);
            chk("freeze_idle_ready", ready[1], 0);
        end
        @(posedge clk);
        #1;
        ena = 1'b1;
        wait_drain();

        // Input churn while busy must not affect the frame or be accepted
        send(0, 8'h3C, 0, 1'b0);
        for (int k = 0; k < 35; k++) begin
            data_in  = 8'($urandom_range(0, 255));
            valid[0] = k[0];
            @(posedge clk);
            #1;
        end
        valid[0] = 1'b0;
        wait_drain();

        // Asynchronous reset mid-frame
        send(0, 8'hC3, 0, 1'b0);
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", tx[0], 1);
        chk("midreset_busy", busy[0], 0);
        sb_q[0].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", ready[0], 1);
        chk("post_reset_tx", tx[0], 1);
        @(posedge clk);
        #1;
        send(0, 8'h81, 0, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
